// File: rtl/ov7670_config_sequencer_if.sv
// Request bus between the OV7670 configuration sequencer and the SCCB sender.
// The sequencer is the only master of the request side; the sender answers
// with a one-cycle taken pulse when it latches a request.
interface ov7670_config_sequencer_if;
   logic       send;
   logic [7:0] id;
   logic [7:0] reg_addr;
   logic [7:0] value;
   logic       taken;

   modport master (
      output send,
      output id,
      output reg_addr,
      output value,
      input  taken
   );

   modport slave (
      input  send,
      input  id,
      input  reg_addr,
      input  value,
      output taken
   );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// OV7670 register-initialisation sequencer.
// Walks a fixed table of {register, value} pairs, presents each write to the
// SCCB sender until it is taken, inserts a settle delay after the soft reset
// entry and raises done at the end marker. resend restarts from entry 0.
module ov7670_config_sequencer #(
   parameter logic [7:0] ID           = 8'h42,
   parameter int         DELAY_CYCLES = 1_000_000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        resend,
   ov7670_config_sequencer_if.master   bus,
   output logic                        done,
   output logic                        busy
);

   localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

   localparam logic [15:0] END_MARK  = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK = 16'hFFF0;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_SEND   = 3'd2,
      ST_DELAY  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         index, index_nxt;
   logic [15:0]        entry, entry_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               send, send_nxt;
   logic [7:0]         reg_addr, reg_addr_nxt;
   logic [7:0]         value, value_nxt;
   logic               done_nxt;
   logic               busy_nxt;

   // Initialisation table; any index not listed reads as the end marker,
   // so the walk always terminates before the index could wrap.
   function automatic logic [15:0] rom_entry(input logic [7:0] idx);
      case (idx)
         8'd0:    rom_entry = 16'h1280;   // COM7 soft reset
         8'd1:    rom_entry = 16'hFFF0;   // settle after soft reset
         8'd2:    rom_entry = 16'h1204;
         8'd3:    rom_entry = 16'h1100;
         8'd4:    rom_entry = 16'h0C00;
         8'd5:    rom_entry = 16'h3E00;
         8'd6:    rom_entry = 16'h8C00;
         8'd7:    rom_entry = 16'h40D0;
         8'd8:    rom_entry = 16'h3A04;
         default: rom_entry = 16'hFFFF;
      endcase
   endfunction

   assign bus.send     = send;
   assign bus.id       = ID;
   assign bus.reg_addr = reg_addr;
   assign bus.value    = value;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_FETCH;
         index    <= 8'd0;
         entry    <= 16'h0000;
         cnt      <= {CNT_W{1'b0}};
         send     <= 1'b0;
         reg_addr <= 8'd0;
         value    <= 8'd0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         index    <= index_nxt;
         entry    <= entry_nxt;
         cnt      <= cnt_nxt;
         send     <= send_nxt;
         reg_addr <= reg_addr_nxt;
         value    <= value_nxt;
         done     <= done_nxt;
         busy     <= busy_nxt;
      end
   end

   // Next-state and next-output logic; resend overrides everything, including taken.
   always_comb begin
      state_nxt    = state;
      index_nxt    = index;
      entry_nxt    = entry;
      cnt_nxt      = cnt;
      send_nxt     = send;
      reg_addr_nxt = reg_addr;
      value_nxt    = value;
      done_nxt     = done;
      busy_nxt     = busy;
      if (resend) begin
         state_nxt = ST_FETCH;
         index_nxt = 8'd0;
         send_nxt  = 1'b0;
         done_nxt  = 1'b0;
         cnt_nxt   = {CNT_W{1'b0}};
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               entry_nxt = rom_entry(index);
               state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
               if (entry == END_MARK) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_DONE;
               end else if (entry == DELAY_MARK) begin
                  cnt_nxt   = CNT_W'(DELAY_CYCLES - 1);
                  state_nxt = ST_DELAY;
               end else begin
                  reg_addr_nxt = entry[15:8];
                  value_nxt    = entry[7:0];
                  send_nxt     = 1'b1;
                  state_nxt    = ST_SEND;
               end
            end
            ST_SEND: begin
               if (bus.taken) begin
                  send_nxt  = 1'b0;
                  index_nxt = index + 8'd1;
                  state_nxt = ST_FETCH;
               end else begin
                  send_nxt = 1'b1;
               end
            end
            ST_DELAY: begin
               send_nxt = 1'b0;
               if (cnt == {CNT_W{1'b0}}) begin
                  index_nxt = index + 8'd1;
                  state_nxt = ST_FETCH;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               send_nxt = 1'b0;
               done_nxt = 1'b1;
            end
            default: begin
               send_nxt  = 1'b0;
               state_nxt = ST_FETCH;
            end
         endcase
         busy_nxt = (state_nxt != ST_DONE);
      end
   end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Self-checking bench for ov7670_config_sequencer: a sender model with random
// latency and random spurious taken pulses, checked against an expected write
// list and issue gaps derived from the register table.
module tb_ov7670_config_sequencer;

   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   logic resend;
   logic done;
   logic busy;

   ov7670_config_sequencer_if bus ();

   ov7670_config_sequencer #(.ID(8'h42), .DELAY_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .resend (resend),
      .bus    (bus),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] tbl [0:9];
   logic [15:0] exp_data [$];
   int          exp_gap  [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Expected writes in order, and the edge count from the preceding release
   // (reset/resend fall or taken edge) to each send rise: FETCH+DECODE, plus
   // FETCH+DECODE+DC delay cycles for every delay entry skipped on the way.
   task automatic build_model();
      int pend;
      pend = 0;
      tbl = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00,
              16'h3E00, 16'h8C00, 16'h40D0, 16'h3A04, 16'hFFFF};
      for (int i = 0; i < 10; i++) begin
         if (tbl[i] == 16'hFFFF) break;
         if (tbl[i] == 16'hFFF0) begin
            pend++;
         end else begin
            exp_data.push_back(tbl[i]);
            exp_gap.push_back(2 + pend * (DC + 2));
            pend = 0;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_send"}, bus.send, 32'd0);
      check_eq({tag, "_addr"}, bus.reg_addr, 32'd0);
      check_eq({tag, "_value"}, bus.value, 32'd0);
      check_eq({tag, "_done"}, done, 32'd0);
      check_eq({tag, "_busy"}, busy, 32'd0);
      check_eq({tag, "_id"}, bus.id, 32'h42);
   endtask

   task automatic do_reset(input int cycles, input string tag);
      reset = 1'b1;
      bus.taken = 1'b0;
      repeat (cycles) tick();
      check_idle(tag);
      reset = 1'b0;
   endtask

   // Wait for the k-th write to be requested, pulsing taken spuriously while send is low.
   task automatic wait_send(input int k);
      int c;
      c = 0;
      while (bus.send !== 1'b1 && c < exp_gap[k] + 40) begin
         bus.taken = ($urandom_range(0, 3) == 0);
         tick();
         c++;
         bus.taken = 1'b0;
      end
      check_eq($sformatf("gap%0d", k), c, exp_gap[k]);
      check_eq($sformatf("data%0d", k), {bus.reg_addr, bus.value}, exp_data[k]);
   endtask

   // Hold the request for lat cycles, then accept it with a one-cycle taken.
   task automatic finish_write(input int k, input int lat);
      int viol;
      viol = 0;
      for (int i = 0; i < lat; i++) begin
         tick();
         if (bus.send !== 1'b1 || {bus.reg_addr, bus.value} !== exp_data[k]) viol++;
      end
      check_eq($sformatf("hold%0d", k), viol, 32'd0);
      bus.taken = 1'b1;
      tick();
      bus.taken = 1'b0;
      check_eq($sformatf("fall%0d", k), bus.send, 32'd0);
   endtask

   task automatic check_done(input string tag);
      int c;
      int viol;
      c = 0;
      while (done !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      check_eq({tag, "_done_lat"}, c, 32'd2);
      check_eq({tag, "_busy"}, busy, 32'd0);
      viol = 0;
      for (int i = 0; i < 1000; i++) begin
         bus.taken = ($urandom_range(0, 3) == 0);
         tick();
         bus.taken = 1'b0;
         if (bus.send !== 1'b0 || done !== 1'b1 || busy !== 1'b0) viol++;
      end
      check_eq({tag, "_quiet"}, viol, 32'd0);
   endtask

   task automatic run_all(input int lat, input string tag);
      for (int k = 0; k < exp_data.size(); k++) begin
         wait_send(k);
         finish_write(k, (lat > 0) ? lat : int'($urandom_range(1, 8)));
      end
      check_done(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.taken = 1'b0;
      resend    = 1'b0;
      reset     = 1'b1;
      build_model();
      check_eq("model_writes", exp_data.size(), 32'd8);

      // Full sequence with fixed 5-cycle sender latency.
      do_reset(3, "por");
      run_all(5, "full");

      // Stalled sender on the first write.
      do_reset(2, "rst2");
      wait_send(0);
      finish_write(0, 500);

      // Reset while the settle delay is running.
      repeat (5) tick();
      do_reset(2, "rst_delay");
      wait_send(0);
      finish_write(0, int'($urandom_range(1, 8)));
      for (int k = 1; k < 3; k++) begin
         wait_send(k);
         finish_write(k, int'($urandom_range(1, 8)));
      end

      // resend during the 4th write, first cycle coincident with taken.
      wait_send(3);
      repeat (2) tick();
      resend    = 1'b1;
      bus.taken = 1'b1;
      tick();
      bus.taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("resend_send%0d", i), bus.send, 32'd0);
         check_eq($sformatf("resend_busy%0d", i), busy, 32'd0);
         check_eq($sformatf("resend_done%0d", i), done, 32'd0);
         if (i < 2) tick();
      end
      resend = 1'b0;
      run_all(0, "restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
